// File: rtl/debounce_pulse.sv
// Two-flop synchroniser plus a four-state qualification FSM that turns a bouncy
// raw line into a clean level and one-cycle rise/fall pulses.
module debounce_pulse #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(STABLE_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             level_next, rise_next, fall_next;
  logic             sync_q1, sync_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1    <= 1'b0;
      sync_q2    <= 1'b0;
      state_reg  <= LOW;
      cnt_reg    <= '0;
      level_out  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      sync_q1    <= raw_in;
      sync_q2    <= sync_q1;
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      level_out  <= level_next;
      rise_pulse <= rise_next;
      fall_pulse <= fall_next;
    end
  end

  // The entry edge into WAIT_* counts as the first stable sample, so the
  // terminal count is STABLE_CYCLES-1 and the counter never needs to wrap.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    level_next = level_out;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state_reg)
      LOW: begin
        if (sync_q2) begin
          state_next = WAIT_HIGH;
          cnt_next   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync_q2) begin
          state_next = LOW;
          cnt_next   = '0;
        end else if (cnt_reg == TERM_CNT) begin
          state_next = HIGH;
          cnt_next   = '0;
          level_next = 1'b1;
          rise_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HIGH: begin
        if (!sync_q2) begin
          state_next = WAIT_LOW;
          cnt_next   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync_q2) begin
          state_next = HIGH;
          cnt_next   = '0;
        end else if (cnt_reg == TERM_CNT) begin
          state_next = LOW;
          cnt_next   = '0;
          level_next = 1'b0;
          fall_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = LOW;
        cnt_next   = '0;
        level_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_debounce_pulse.sv
// Bench for debounce_pulse: directed scenarios with hand-derived edge numbers,
// plus randomized run-length stimulus against a run-length reference model.
module tb_debounce_pulse;

  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic raw_in = 1'b0;
  logic level_out, rise_pulse, fall_pulse;

  int total = 0;
  int bad   = 0;

  // Reference model: the line seen by the qualifier is raw_in delayed by two
  // edges; the level flips once the delayed line has disagreed with it on
  // STABLE+1 consecutive edges.
  logic m_dly[2];
  int   m_run;
  logic m_level, m_rise, m_fall;

  debounce_pulse #(.STABLE_CYCLES(STABLE), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .level_out (level_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input logic r, input logic rs);
    logic seen;
    if (rs) begin
      m_dly[0] = 1'b0; m_dly[1] = 1'b0;
      m_run = 0; m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
    end else begin
      seen   = m_dly[1];
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (seen != m_level) begin
        m_run++;
        if (m_run == STABLE + 1) begin
          m_level = seen;
          m_rise  = seen;
          m_fall  = ~seen;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
      m_dly[1] = m_dly[0];
      m_dly[0] = r;
    end
  endtask

  // Drive one cycle of stimulus, advance the model, and settle past the edge.
  task automatic tick(input logic r, input logic rs);
    raw_in = r;
    rst    = rs;
    @(posedge clk);
    model_edge(r, rs);
    #1;
  endtask

  task automatic test_reset;
    logic [2:0] got, want;
    for (int k = 1; k <= 14; k++) begin
      tick(1'b1, k <= 4);
      got  = {level_out, rise_pulse, fall_pulse};
      want = {k >= 11, k == 11, 1'b0};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL reset_const edge=%0d got=%b want=%b", k, got, want);
      end
      total++;
      if (got !== {m_level, m_rise, m_fall}) begin
        bad++;
        $display("FAIL reset_model edge=%0d got=%b want=%b", k, got, {m_level, m_rise, m_fall});
      end
    end
  endtask

  task automatic test_clean_press;
    logic [2:0] got, want;
    tick(1'b0, 1'b1);
    for (int k = 1; k <= 45; k++) begin
      tick(k >= 10 && k <= 29, 1'b0);
      got  = {level_out, rise_pulse, fall_pulse};
      want = {k >= 16 && k <= 35, k == 16, k == 36};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL clean_const edge=%0d got=%b want=%b", k, got, want);
      end
      total++;
      if (got !== {m_level, m_rise, m_fall}) begin
        bad++;
        $display("FAIL clean_model edge=%0d got=%b want=%b", k, got, {m_level, m_rise, m_fall});
      end
    end
  endtask

  task automatic test_glitch_width;
    logic [2:0] got, want;
    tick(1'b0, 1'b1);
    for (int k = 1; k <= 50; k++) begin
      tick((k >= 10 && k <= 13) || (k >= 30 && k <= 34), 1'b0);
      got  = {level_out, rise_pulse, fall_pulse};
      want = {k >= 36 && k <= 40, k == 36, k == 41};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL glitch_const edge=%0d got=%b want=%b", k, got, want);
      end
      total++;
      if (got !== {m_level, m_rise, m_fall}) begin
        bad++;
        $display("FAIL glitch_model edge=%0d got=%b want=%b", k, got, {m_level, m_rise, m_fall});
      end
    end
  endtask

  task automatic test_bounce;
    logic [2:0] got, want;
    logic r;
    tick(1'b0, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      if (k < 20)      r = 1'b0;
      else if (k > 24) r = 1'b1;
      else             r = ((k - 20) % 2) == 0;
      tick(r, 1'b0);
      got  = {level_out, rise_pulse, fall_pulse};
      want = {k >= 30, k == 30, 1'b0};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL bounce_const edge=%0d got=%b want=%b", k, got, want);
      end
      total++;
      if (got !== {m_level, m_rise, m_fall}) begin
        bad++;
        $display("FAIL bounce_model edge=%0d got=%b want=%b", k, got, {m_level, m_rise, m_fall});
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [2:0] got, want;
    tick(1'b0, 1'b1);
    for (int k = 1; k <= 25; k++) begin
      tick(k >= 10, k == 13);
      got  = {level_out, rise_pulse, fall_pulse};
      want = {k >= 20, k == 20, 1'b0};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL rstmid_const edge=%0d got=%b want=%b", k, got, want);
      end
      total++;
      if (got !== {m_level, m_rise, m_fall}) begin
        bad++;
        $display("FAIL rstmid_model edge=%0d got=%b want=%b", k, got, {m_level, m_rise, m_fall});
      end
    end
  endtask

  task automatic test_long_hold;
    logic [2:0] got, want;
    tick(1'b0, 1'b1);
    for (int k = 1; k <= 125; k++) begin
      tick(k <= 100 || k >= 104, 1'b0);
      got  = {level_out, rise_pulse, fall_pulse};
      want = {k >= 7, k == 7, 1'b0};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL hold_const edge=%0d got=%b want=%b", k, got, want);
      end
      total++;
      if (got !== {m_level, m_rise, m_fall}) begin
        bad++;
        $display("FAIL hold_model edge=%0d got=%b want=%b", k, got, {m_level, m_rise, m_fall});
      end
    end
  endtask

  // Run lengths of 1..8 cluster around the STABLE/STABLE+1 boundary.
  task automatic test_random;
    logic [2:0] got;
    logic r;
    int   left, k;
    r = 1'b0; left = 0; k = 0;
    tick(1'b0, 1'b1);
    while (k < 3000) begin
      if (left == 0) begin
        r    = ~r;
        left = $urandom_range(8, 1);
      end
      tick(r, $urandom_range(299, 0) == 0);
      left--;
      k++;
      got = {level_out, rise_pulse, fall_pulse};
      total++;
      if (got !== {m_level, m_rise, m_fall}) begin
        bad++;
        $display("FAIL random_model cycle=%0d got=%b want=%b", k, got, {m_level, m_rise, m_fall});
      end
    end
  endtask

  initial begin
    m_dly[0] = 1'b0; m_dly[1] = 1'b0;
    m_run = 0; m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
    test_reset();
    test_clean_press();
    test_glitch_width();
    test_bounce();
    test_reset_mid();
    test_long_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
